// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared types and encodings for the multi-cycle RV32I controller
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } mc_state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I      = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } instr_cls_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_ALU    = 2'd2;

  localparam logic [1:0] ASRC_RS1  = 2'd0;
  localparam logic [1:0] ASRC_PC   = 2'd1;
  localparam logic [1:0] ASRC_ZERO = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MDR = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/header.sv
//------------------------------------------------------------------------------
// header : immediate-generator select codes shared with the datapath
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef HEADER_SV
`define HEADER_SV
`define IMMGEN_I  3'd0
`define IMMGEN_S  3'd1
`define IMMGEN_SB 3'd2
`define IMMGEN_U  3'd3
`define IMMGEN_UJ 3'd4
`endif

`default_nettype wire

// File: rtl/my_opdec.sv
//------------------------------------------------------------------------------
// my_opdec : opcode -> instruction class, legality and EXEC immediate select
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
`ifndef IMMGEN_I
`include "header.sv"
`endif

module my_opdec
  import cpu_pkg::*;
(
  input  logic [6:0] i_opcode,
  output instr_cls_t o_cls,
  output logic       o_legal,
  output logic [2:0] o_imm_sel
);

  always_comb begin
    o_cls     = CLS_NONE;
    o_legal   = 1'b1;
    o_imm_sel = `IMMGEN_I;
    case (i_opcode)
      OPC_R:      o_cls = CLS_R;
      OPC_IALU:   o_cls = CLS_I;
      OPC_LOAD:   o_cls = CLS_LOAD;
      OPC_STORE:  begin o_cls = CLS_STORE;  o_imm_sel = `IMMGEN_S;  end
      OPC_BRANCH: begin o_cls = CLS_BRANCH; o_imm_sel = `IMMGEN_SB; end
      OPC_JAL:    begin o_cls = CLS_JAL;    o_imm_sel = `IMMGEN_UJ; end
      OPC_JALR:   o_cls = CLS_JALR;
      OPC_LUI:    begin o_cls = CLS_LUI;    o_imm_sel = `IMMGEN_U;  end
      OPC_AUIPC:  begin o_cls = CLS_AUIPC;  o_imm_sel = `IMMGEN_U;  end
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/my_mc_ctrl.sv
//------------------------------------------------------------------------------
// my_mc_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I
// Optional perf counters enabled by defining MC_CTRL_PERF_EN.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
`ifndef IMMGEN_I
`include "header.sv"
`endif

module my_mc_ctrl
  import cpu_pkg::*;
`ifdef MC_CTRL_PERF_EN
#(
  parameter int unsigned PERF_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRW,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MDRWrite,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcA,
  output logic        ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  WBSel,
  output logic [2:0]  ImmSel,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  mc_state_t  r_state;
  mc_state_t  w_next_state;
  instr_cls_t w_cls;
  logic       w_legal;
  logic [2:0] w_exec_imm;
  logic       w_instr_unused;

  logic       w_mem_req, w_mem_rw, w_iord, w_ir_write, w_pc_write;
  logic       w_reg_write, w_mdr_write, w_alu_src_b, w_illegal;
  logic [1:0] w_pc_src, w_alu_src_a, w_alu_op, w_wb_sel;
  logic [2:0] w_imm_sel;

  // Funct fields are decoded by the datapath's ALU control, not here.
  assign w_instr_unused = ^instr[31:7];

  my_opdec u_opdec (
    .i_opcode  (instr[6:0]),
    .o_cls     (w_cls),
    .o_legal   (w_legal),
    .o_imm_sel (w_exec_imm)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:  if (mem_ready) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = w_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (w_cls)
          CLS_R, CLS_I, CLS_LUI, CLS_AUIPC: w_next_state = ST_WB;
          CLS_LOAD, CLS_STORE:              w_next_state = ST_MEM;
          default:                          w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) w_next_state = (w_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   w_next_state = ST_FETCH;
      ST_TRAP: w_next_state = ST_TRAP;
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_rw    = 1'b0;
    w_iord      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mdr_write = 1'b0;
    w_illegal   = 1'b0;
    w_pc_src    = PCSRC_PC4;
    w_alu_src_a = ASRC_RS1;
    w_alu_src_b = 1'b0;
    w_alu_op    = ALUOP_ADD;
    w_wb_sel    = WBSEL_ALU;
    w_imm_sel   = `IMMGEN_I;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      // Speculative branch target (PC + SB imm) lands in ALUOut.
      ST_DECODE: begin
        w_alu_src_a = ASRC_PC;
        w_alu_src_b = 1'b1;
        w_imm_sel   = `IMMGEN_SB;
      end
      ST_EXEC: begin
        w_imm_sel = w_exec_imm;
        case (w_cls)
          CLS_R: w_alu_op = ALUOP_FUNCT;
          CLS_I: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = ALUOP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: w_alu_src_b = 1'b1;
          CLS_BRANCH: begin
            w_alu_op   = ALUOP_CMP;
            w_pc_write = branch_taken;
            w_pc_src   = PCSRC_ALUOUT;
          end
          CLS_JAL, CLS_JALR: begin
            w_alu_src_a = (w_cls == CLS_JAL) ? ASRC_PC : ASRC_RS1;
            w_alu_src_b = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_src    = PCSRC_ALU;
            w_reg_write = 1'b1;
            w_wb_sel    = WBSEL_PC4;
          end
          CLS_LUI, CLS_AUIPC: begin
            w_alu_src_a = (w_cls == CLS_LUI) ? ASRC_ZERO : ASRC_PC;
            w_alu_src_b = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_mem_rw    = (w_cls == CLS_STORE);
        w_mdr_write = mem_ready && (w_cls == CLS_LOAD);
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = (w_cls == CLS_LOAD) ? WBSEL_MDR : WBSEL_ALU;
      end
      ST_TRAP: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset silences every output in the same cycle, including an open request.
  assign mem_req  = w_mem_req   & ~rst;
  assign MemRW    = w_mem_rw    & ~rst;
  assign IorD     = w_iord      & ~rst;
  assign IRWrite  = w_ir_write  & ~rst;
  assign PCWrite  = w_pc_write  & ~rst;
  assign RegWrite = w_reg_write & ~rst;
  assign MDRWrite = w_mdr_write & ~rst;
  assign ALUSrcB  = w_alu_src_b & ~rst;
  assign illegal  = w_illegal   & ~rst;
  assign PCSrc    = rst ? 2'd0 : w_pc_src;
  assign ALUSrcA  = rst ? 2'd0 : w_alu_src_a;
  assign ALUOp    = rst ? 2'd0 : w_alu_op;
  assign WBSel    = rst ? 2'd0 : w_wb_sel;
  assign ImmSel   = rst ? 3'd0 : w_imm_sel;

`ifdef MC_CTRL_PERF_EN
  logic [PERF_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0] r_instret_cnt;
  logic              w_retire;

  assign w_retire = (w_next_state == ST_FETCH) &&
                    (r_state != ST_FETCH) && (r_state != ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire) r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_my_mc_ctrl.sv
//------------------------------------------------------------------------------
// tb_my_mc_ctrl : self-checking bench for my_mc_ctrl (optionally MC_CTRL_PERF_EN)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none
`ifndef IMMGEN_I
`include "header.sv"
`endif

module tb_my_mc_ctrl;

  typedef struct packed {
    logic       mem_req, MemRW, IorD, IRWrite, PCWrite, RegWrite, MDRWrite;
    logic [1:0] PCSrc, ALUSrcA;
    logic       ALUSrcB;
    logic [1:0] ALUOp, WBSel;
    logic [2:0] ImmSel;
    logic       illegal;
  } ctl_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;
  localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LOAD = 3, C_STORE = 4, C_BR = 5,
                 C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        branch_taken, mem_ready;
  logic        mem_req, MemRW, IorD, IRWrite, PCWrite, RegWrite, MDRWrite, ALUSrcB, illegal;
  logic [1:0]  PCSrc, ALUSrcA, ALUOp, WBSel;
  logic [2:0]  ImmSel;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  ctl_t        obs;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  my_mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemRW(MemRW), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MDRWrite(MDRWrite),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .WBSel(WBSel), .ImmSel(ImmSel), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  assign obs = {mem_req, MemRW, IorD, IRWrite, PCWrite, RegWrite, MDRWrite,
                PCSrc, ALUSrcA, ALUSrcB, ALUOp, WBSel, ImmSel, illegal};

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  // Expected outputs per phase; the mask selects the fields that phase defines.
  task automatic expect_phase(input int ph, input int cls, input bit rdy, input bit tk,
                              output ctl_t e, output ctl_t m);
    e = '0; m = '0;
    m.mem_req = 1; m.IRWrite = 1; m.PCWrite = 1; m.RegWrite = 1; m.MDRWrite = 1;
    m.illegal = 1; m.ImmSel = '1; e.ImmSel = `IMMGEN_I;
    case (ph)
      P_FETCH: begin
        e.mem_req = 1; m.IorD = 1; m.MemRW = 1;
        if (rdy) begin e.IRWrite = 1; e.PCWrite = 1; e.PCSrc = 2'd0; m.PCSrc = '1; end
      end
      P_DECODE: begin
        e.ALUSrcA = 2'd1; e.ALUSrcB = 1; e.ImmSel = `IMMGEN_SB; e.ALUOp = 2'b00;
        m.ALUSrcA = '1; m.ALUSrcB = 1; m.ALUOp = '1;
        if (cls == C_ILL) m.illegal = 0;
      end
      P_EXEC: begin
        case (cls)
          C_R: begin
            e.ALUSrcA = 0; e.ALUSrcB = 0; e.ALUOp = 2'b10;
            m.ALUSrcA = '1; m.ALUSrcB = 1; m.ALUOp = '1; m.ImmSel = '0;
          end
          C_I: begin
            e.ALUSrcB = 1; e.ALUOp = 2'b10; m.ALUSrcB = 1; m.ALUOp = '1;
          end
          C_LOAD, C_STORE: begin
            e.ALUSrcA = 0; e.ALUSrcB = 1; e.ALUOp = 2'b00;
            m.ALUSrcA = '1; m.ALUSrcB = 1; m.ALUOp = '1;
            e.ImmSel = (cls == C_LOAD) ? `IMMGEN_I : `IMMGEN_S;
          end
          C_BR: begin
            e.ALUOp = 2'b01; m.ALUOp = '1; e.PCWrite = tk; e.PCSrc = 2'd1; m.PCSrc = '1;
            m.ImmSel = '0;
          end
          C_JAL, C_JALR: begin
            e.ALUSrcA = (cls == C_JAL) ? 2'd1 : 2'd0; m.ALUSrcA = '1;
            e.ImmSel  = (cls == C_JAL) ? `IMMGEN_UJ : `IMMGEN_I;
            e.PCWrite = 1; e.PCSrc = 2'd2; e.RegWrite = 1; e.WBSel = 2'd2;
            m.PCSrc = '1; m.WBSel = '1;
          end
          default: begin
            e.ALUSrcA = (cls == C_LUI) ? 2'd2 : 2'd1; m.ALUSrcA = '1;
            e.ImmSel = `IMMGEN_U;
          end
        endcase
      end
      P_MEM: begin
        e.mem_req = 1; e.IorD = 1; e.MemRW = (cls == C_STORE); m.IorD = 1; m.MemRW = 1;
        e.MDRWrite = rdy && (cls == C_LOAD);
      end
      P_WB: begin
        e.RegWrite = 1; e.WBSel = (cls == C_LOAD) ? 2'd1 : 2'd0; m.WBSel = '1;
      end
      default: e.illegal = 1;
    endcase
  endtask

  task automatic check_ctl(input string tag, input ctl_t e, input ctl_t m);
    checks++;
    assert ((obs & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h mask=%h", tag, obs & m, e & m, m);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One controller cycle: drive inputs, check settled outputs, advance a clock.
  task automatic cyc(input int ph, input int cls, input bit rdy, input bit tk, input string tag);
    ctl_t e, m;
    mem_ready = rdy;
    branch_taken = tk;
    #1;
    expect_phase(ph, cls, rdy, tk, e, m);
    check_ctl(tag, e, m);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int fw, input int mw,
                           input bit tk, input string tag);
    int cls;
    cls = cls_of(ir[6:0]);
    instr = ir;
    for (int i = 0; i < fw; i++) cyc(P_FETCH, cls, 1'b0, 1'($urandom), {tag, "/fetchwait"});
    cyc(P_FETCH, cls, 1'b1, 1'($urandom), {tag, "/fetch"});
    cyc(P_DECODE, cls, 1'($urandom), 1'($urandom), {tag, "/decode"});
    if (cls == C_ILL) return;
    cyc(P_EXEC, cls, 1'($urandom), tk, {tag, "/exec"});
    if (cls == C_LOAD || cls == C_STORE) begin
      for (int i = 0; i < mw; i++) cyc(P_MEM, cls, 1'b0, 1'($urandom), {tag, "/memwait"});
      cyc(P_MEM, cls, 1'b1, 1'($urandom), {tag, "/mem"});
    end
    if (cls != C_STORE && cls != C_BR && cls != C_JAL && cls != C_JALR)
      cyc(P_WB, cls, 1'($urandom), 1'($urandom), {tag, "/wb"});
  endtask

  task automatic check_zero(input string tag);
    #1;
    check_ctl(tag, '0, '1);
  endtask

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;

    run_instr(32'h00500093, 0, 0, 1'b0, "addi");
    run_instr(32'h00002083, 0, 2, 1'b0, "lw_wait2");
    run_instr(32'h00000063, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h00001063, 0, 0, 1'b0, "bne_nottaken");
    run_instr(32'h0000006F, 0, 0, 1'b0, "jal");
    run_instr(32'h00102023, 1, 1, 1'b0, "sw_waits");

    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      run_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 2),
                $urandom_range(0, 2), 1'($urandom), "random");
    end

`ifdef MC_CTRL_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 10; n++) run_instr(32'h00500093, 0, 0, 1'b0, "perf_addi");
    check_val("instret_10", instret_cnt, 32'd10);
    check_val("cycle_40", cycle_cnt, 32'd40);
`endif

    // Reset while a store is waiting in MEM.
    instr = 32'h00102023;
    cyc(P_FETCH, C_STORE, 1'b1, 1'b0, "sw_rst/fetch");
    cyc(P_DECODE, C_STORE, 1'b0, 1'b0, "sw_rst/decode");
    cyc(P_EXEC, C_STORE, 1'b0, 1'b0, "sw_rst/exec");
    cyc(P_MEM, C_STORE, 1'b0, 1'b0, "sw_rst/memwait");
    rst = 1'b1; mem_ready = 1'b1;
    check_zero("sw_rst/rst_in_mem");
    @(posedge clk); #1;
    check_zero("sw_rst/rst_held");
`ifdef MC_CTRL_PERF_EN
    check_val("sw_rst/cycle_clr", cycle_cnt, 32'd0);
    check_val("sw_rst/instret_clr", instret_cnt, 32'd0);
`endif
    rst = 1'b0;
    cyc(P_FETCH, C_STORE, 1'b0, 1'b0, "sw_rst/fetch_after");

    // Illegal opcode traps until reset.
    run_instr(32'h00000000, 0, 0, 1'b0, "illegal");
    for (int n = 0; n < 5; n++) cyc(P_TRAP, C_ILL, 1'($urandom), 1'($urandom), "trap_hold");
    rst = 1'b1;
    check_zero("trap_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(P_FETCH, C_ILL, 1'b0, 1'b0, "trap_exit_fetch");
    run_instr(32'h00500093, 0, 0, 1'b0, "addi_after_trap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
